// File: rtl/verificador_circuito_dois_pkg.sv
// Shared types and helpers for the 3-input AND circuit checker.
// The state enum, the number of input combinations and the reference
// function for the circuit under test (x = a & b & c).
package verif_circuito_dois_pkg;

  typedef enum logic [2:0] {
    OCIOSO,
    APLICA,
    ESPERA,
    AMOSTRA,
    FIM
  } estado_t;

  localparam int N_COMB = 8;

  // Expected output of the AND circuit for a given {a,b,c} combination.
  function automatic logic esperado(input logic [2:0] comb);
    return &comb;
  endfunction

endpackage

// File: rtl/verificador_circuito_dois_temporizador.sv
// Settle-wait timer: loadable 4-bit down-counter that stops at zero.
// zero is asserted while the count is 0, so a load of N holds zero low
// for N cycles after the load edge.
module temporizador_espera (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       carga,
  input  logic [3:0] valor,
  output logic       zero
);

  logic [3:0] cont_q;
  logic [3:0] cont_d;

  // Load on request, otherwise count down and hold at zero.
  always_comb begin
    cont_d = cont_q;
    if (carga) begin
      cont_d = valor;
    end else if (cont_q != 4'd0) begin
      cont_d = cont_q - 4'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cont_q <= 4'd0;
    end else begin
      cont_q <= cont_d;
    end
  end

  assign zero = (cont_q == 4'd0);

endmodule

// File: rtl/verificador_circuito_dois.sv
// Stimulus/check end for the 3-input AND circuit (x = a & b & c).
// On inicio, walks {a,b,c} through 000..111, waits ESPERA settle cycles per
// combination, samples x and counts mismatches against a&b&c.
// Optional feature macro: VERIF_CIRCUITO_DOIS_TABELA_EN adds the tabela port
// holding the captured x for every combination.
module verificador_circuito_dois #(
  parameter int ESPERA = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inicio,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       x,
  output logic       ocupado,
  output logic       concluido,
  output logic       aprovado,
  output logic [3:0] erros
`ifdef VERIF_CIRCUITO_DOIS_TABELA_EN
  ,
  output logic [7:0] tabela
`endif
);

  import verif_circuito_dois_pkg::*;

  // The module parameter shadows the state literal of the same name.
  localparam estado_t   EST_ESPERA   = verif_circuito_dois_pkg::ESPERA;
  localparam logic [3:0] CARGA_TIMER = 4'(ESPERA - 1);
  localparam logic [2:0] ULTIMA_COMB = 3'(N_COMB - 1);

  estado_t    estado_q, estado_d;
  logic [2:0] comb_q, comb_d;
  logic [3:0] erros_q, erros_d;
  logic       aprovado_q, aprovado_d;
  logic       carga;
  logic       timer_zero;
  logic       aplicando;
`ifdef VERIF_CIRCUITO_DOIS_TABELA_EN
  logic [7:0] tabela_q, tabela_d;
`endif

  temporizador_espera u_temporizador (
    .clk   (clk),
    .rst_n (rst_n),
    .carga (carga),
    .valor (CARGA_TIMER),
    .zero  (timer_zero)
  );

  // Next-state logic: sequence the combinations and accumulate the result.
  always_comb begin
    estado_d   = estado_q;
    comb_d     = comb_q;
    erros_d    = erros_q;
    aprovado_d = aprovado_q;
    carga      = 1'b0;
    concluido  = 1'b0;
`ifdef VERIF_CIRCUITO_DOIS_TABELA_EN
    tabela_d   = tabela_q;
`endif
    case (estado_q)
      OCIOSO: begin
        if (inicio) begin
          estado_d   = APLICA;
          comb_d     = 3'd0;
          erros_d    = 4'd0;
          aprovado_d = 1'b0;
`ifdef VERIF_CIRCUITO_DOIS_TABELA_EN
          tabela_d   = 8'h00;
`endif
        end
      end
      APLICA: begin
        carga    = 1'b1;
        estado_d = EST_ESPERA;
      end
      EST_ESPERA: begin
        if (timer_zero) begin
          estado_d = AMOSTRA;
        end
      end
      AMOSTRA: begin
`ifdef VERIF_CIRCUITO_DOIS_TABELA_EN
        tabela_d[comb_q] = x;
`endif
        if (x != esperado(comb_q)) begin
          erros_d = erros_q + 4'd1;
        end
        if (comb_q == ULTIMA_COMB) begin
          estado_d = FIM;
        end else begin
          comb_d   = comb_q + 3'd1;
          estado_d = APLICA;
        end
      end
      FIM: begin
        concluido  = 1'b1;
        aprovado_d = (erros_q == 4'd0);
        estado_d   = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  // State and result registers; reset aborts any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q   <= OCIOSO;
      comb_q     <= 3'd0;
      erros_q    <= 4'd0;
      aprovado_q <= 1'b0;
`ifdef VERIF_CIRCUITO_DOIS_TABELA_EN
      tabela_q   <= 8'h00;
`endif
    end else begin
      estado_q   <= estado_d;
      comb_q     <= comb_d;
      erros_q    <= erros_d;
      aprovado_q <= aprovado_d;
`ifdef VERIF_CIRCUITO_DOIS_TABELA_EN
      tabela_q   <= tabela_d;
`endif
    end
  end

  // a,b,c carry the current combination from APLICA through AMOSTRA only.
  assign aplicando = (estado_q == APLICA) || (estado_q == EST_ESPERA) ||
                     (estado_q == AMOSTRA);
  assign {a, b, c} = aplicando ? comb_q : 3'b000;
  assign ocupado   = (estado_q != OCIOSO);
  assign aprovado  = aprovado_q;
  assign erros     = erros_q;
`ifdef VERIF_CIRCUITO_DOIS_TABELA_EN
  assign tabela    = tabela_q;
`endif

endmodule

// File: tb/tb_verificador_circuito_dois.sv
// Bench for verificador_circuito_dois: one instance with ESPERA=1 driven
// against a configurable fault table, one with ESPERA=3 against an ideal AND.
module tb_verificador_circuito_dois;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       inicio1, inicio3;
  logic       a1, b1, c1, x1, oc1, con1, apr1;
  logic       a3, b3, c3, x3, oc3, con3, apr3;
  logic [3:0] err1, err3;
  logic [7:0] xtab1;
`ifdef VERIF_CIRCUITO_DOIS_TABELA_EN
  logic [7:0] tab1, tab3;
`endif

  // Circuit under test seen by dut1: x looked up from a table indexed by {a,b,c}.
  assign x1 = xtab1[{a1, b1, c1}];
  assign x3 = a3 & b3 & c3;

  verificador_circuito_dois #(.ESPERA(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .inicio(inicio1),
    .a(a1), .b(b1), .c(c1), .x(x1),
    .ocupado(oc1), .concluido(con1), .aprovado(apr1), .erros(err1)
`ifdef VERIF_CIRCUITO_DOIS_TABELA_EN
    , .tabela(tab1)
`endif
  );

  verificador_circuito_dois #(.ESPERA(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .inicio(inicio3),
    .a(a3), .b(b3), .c(c3), .x(x3),
    .ocupado(oc3), .concluido(con3), .aprovado(apr3), .erros(err3)
`ifdef VERIF_CIRCUITO_DOIS_TABELA_EN
    , .tabela(tab3)
`endif
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string nome, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nome, act, exp);
    end
  endtask

  // Reference: number of combinations whose x differs from an ideal AND.
  function automatic int modelo_erros(input logic [7:0] t);
    int n = 0;
    for (int i = 0; i < 8; i++) begin
      if (t[i] != (i == 7)) n++;
    end
    return n;
  endfunction

  typedef struct {
    logic [7:0] xtab;
    int         exp_erros;
    logic       exp_aprov;
  } vec_t;

  vec_t vecs[5];

  // One full run on dut1 with a given fault table; checks timing, sequence and result.
  task automatic run1(input string nome, input logic [7:0] t, input int exp_err,
                      input logic exp_apr);
    int   con_cycle = -1;
    int   con_count = 0;
    logic seq_ok = 1'b1;
    logic oc_ok = 1'b1;
    xtab1 = t;
    @(negedge clk);
    inicio1 = 1'b1;
    @(negedge clk);
    inicio1 = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (con1) begin
        con_count++;
        if (con_cycle < 0) con_cycle = k;
      end
      if (k <= 24 && {a1, b1, c1} != 3'((k - 1) / 3)) seq_ok = 1'b0;
      if (oc1 != (k <= 25)) oc_ok = 1'b0;
      @(negedge clk);
    end
    check({nome, " concluido_cycle"}, con_cycle, 25);
    check({nome, " concluido_count"}, con_count, 1);
    check({nome, " erros"}, int'(err1), exp_err);
    check({nome, " aprovado"}, int'(apr1), int'(exp_apr));
    check({nome, " abc_seq"}, int'(seq_ok), 1);
    check({nome, " ocupado"}, int'(oc_ok), 1);
`ifdef VERIF_CIRCUITO_DOIS_TABELA_EN
    check({nome, " tabela"}, int'(tab1), int'(t));
`endif
    $display("run %s xtab=%02h erros=%0d aprovado=%0d", nome, t, err1, apr1);
  endtask

  initial begin
    int   con_cycle;
    int   con_count;
    logic t1_ok;
    logic [7:0] t;

    vecs[0] = '{8'h80, 0, 1'b1};
    vecs[1] = '{8'h00, 1, 1'b0};
    vecs[2] = '{8'hFF, 7, 1'b0};
    vecs[3] = '{8'h7F, 8, 1'b0};
    vecs[4] = '{8'h01, 2, 1'b0};

    // Reset and idle.
    rst_n = 1'b0; inicio1 = 1'b0; inicio3 = 1'b0; xtab1 = 8'h80;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    t1_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (con1 || oc1) t1_ok = 1'b0;
    end
    check("reset abc", int'({a1, b1, c1}), 0);
    check("reset ocupado", int'(oc1), 0);
    check("reset concluido", int'(con1), 0);
    check("reset aprovado", int'(apr1), 0);
    check("reset erros", int'(err1), 0);
    check("idle quiet", int'(t1_ok), 1);
    $display("reset idle abc=%0d ocupado=%0d erros=%0d", {a1, b1, c1}, oc1, err1);

    // Table-driven runs: ideal, stuck-at-0, stuck-at-1, inverted, mixed.
    foreach (vecs[i]) begin
      run1($sformatf("vec%0d", i), vecs[i].xtab, vecs[i].exp_erros, vecs[i].exp_aprov);
    end

    // Random fault tables against the reference model.
    for (int r = 0; r < 12; r++) begin
      t = 8'($urandom);
      run1($sformatf("rnd%0d", r), t, modelo_erros(t), modelo_erros(t) == 0);
    end

    // Reset during combination 4.
    xtab1 = 8'hFF;
    @(negedge clk);
    inicio1 = 1'b1;
    @(negedge clk);
    inicio1 = 1'b0;
    repeat (13) @(negedge clk);
    check("midrun abc", int'({a1, b1, c1}), 4);
    rst_n = 1'b0;
    #1;
    check("abort abc", int'({a1, b1, c1}), 0);
    check("abort ocupado", int'(oc1), 0);
    check("abort concluido", int'(con1), 0);
    check("abort erros", int'(err1), 0);
    t1_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (con1) t1_ok = 1'b0;
    end
    check("abort no_concluido", int'(t1_ok), 1);
    rst_n = 1'b1;
    $display("abort at comb 4 done");
    run1("after_abort", 8'h80, 0, 1'b1);

    // inicio held high: the next run starts on the first idle cycle after FIM.
    xtab1 = 8'h80;
    @(negedge clk);
    inicio1 = 1'b1;
    con_cycle = -1;
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk);
      if (con1 && con_cycle < 0) con_cycle = k;
      if (k == 26) check("held idle ocupado", int'(oc1), 0);
      if (k == 27) check("held restart ocupado", int'(oc1), 1);
    end
    inicio1 = 1'b0;
    check("held concluido_cycle", con_cycle, 25);
    repeat (30) @(negedge clk);
    check("held second aprovado", int'(apr1), 1);
    $display("held inicio run done erros=%0d", err1);

    // ESPERA=3 with a second inicio pulse while busy.
    @(negedge clk);
    inicio3 = 1'b1;
    @(negedge clk);
    inicio3 = 1'b0;
    con_cycle = -1;
    con_count = 0;
    for (int k = 1; k <= 50; k++) begin
      if (k == 10) inicio3 = 1'b1;
      if (k == 11) inicio3 = 1'b0;
      if (con3) begin
        con_count++;
        if (con_cycle < 0) con_cycle = k;
      end
      @(negedge clk);
    end
    check("e3 concluido_cycle", con_cycle, 41);
    check("e3 concluido_count", con_count, 1);
    check("e3 erros", int'(err3), 0);
    check("e3 aprovado", int'(apr3), 1);
`ifdef VERIF_CIRCUITO_DOIS_TABELA_EN
    check("e3 tabela", int'(tab3), 8'h80);
`endif
    $display("espera3 run concluido_cycle=%0d erros=%0d", con_cycle, err3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
